operand_stage: RTL and testbench
================================

// Module: operand_stage
// PURPOSE
//  Decode/operand stage directly upstream of the 8-bit ALU: decodes one 32-bit instruction per cycle.
//  Reads source registers and drives registered DATA1/DATA2/SELECT into the ALU.
//  Writes the ALU RESULT back to the destination register one cycle later, with bypass for back-to-back dependencies.
//  Instruction fields: OP=[31:24], DEST=[18:16], SRC1=[10:8], SRC2=[2:0], IMM=[7:0].
// PARAMETERS
//  DATA_W   8  operand/register width
//  ADDR_W   3  register address width
//  NREGS    8  register count (2**ADDR_W)
// PORTS
//  CLK          in   1       clock, all state updates on posedge
//  RESET        in   1       synchronous, active-high reset
//  INSTRUCTION  in   32      instruction word, sampled when INSTR_VALID=1
//  INSTR_VALID  in   1       instruction present this cycle
//  ALU_RESULT   in   DATA_W  ALU RESULT; combinationally valid in the cycle after issue
//  DATA1        out  DATA_W  registered ALU operand 1 (reg[SRC1])
//  DATA2        out  DATA_W  registered ALU operand 2 (reg[SRC2], -reg[SRC2], or IMM)
//  SELECT       out  3       registered ALU op: 000 fwd, 001 add, 010 and, 011 or
//  WB_EN        out  1       high in the cycle whose closing edge writes ALU_RESULT to reg[WB_ADDR]
//  WB_ADDR      out  ADDR_W  destination of the pending writeback
//  ILLEGAL_OP   out  1       one-cycle pulse, cycle after an undefined opcode was sampled
// BEHAVIOUR
//  Reset: on posedge with RESET=1:
//   - all registers, DATA1, DATA2, SELECT, WB_ADDR := 0
//   - WB_EN, ILLEGAL_OP := 0
//   - a pending writeback in flight is dropped, not written.
//  Issue (edge N, INSTR_VALID=1): DATA1/DATA2/SELECT/WB_ADDR load from decode; WB_EN:=1 for legal ops.
//  Writeback (edge N+1): if WB_EN=1, reg[WB_ADDR] := ALU_RESULT. Latency issue->register update = 2 edges.
//  Opcodes:
//   - 0x00 loadi: SELECT=000, DATA2=IMM
//   - 0x01 mov:   SELECT=000, DATA2=reg[SRC2]
//   - 0x02 add:   SELECT=001, DATA1=reg[SRC1], DATA2=reg[SRC2]
//   - 0x03 sub:   SELECT=001, DATA1=reg[SRC1], DATA2=(~reg[SRC2])+1, modulo 2**DATA_W
//   - 0x04 and:   SELECT=010, DATA1=reg[SRC1], DATA2=reg[SRC2]
//   - 0x05 or:    SELECT=011, DATA1=reg[SRC1], DATA2=reg[SRC2]
//   - other: WB_EN:=0, ILLEGAL_OP:=1, DATA1/DATA2/SELECT hold.
//  INSTR_VALID=0: WB_EN:=0, ILLEGAL_OP:=0, DATA1/DATA2/SELECT/WB_ADDR hold.
//  Bypass: if WB_EN=1 and SRCx==WB_ADDR at an issue edge, operand x uses ALU_RESULT, not the stale reg.
//   - Applies to SRC1 and SRC2 independently; sub negates the bypassed value.
//  Register file reads are combinational; write and issue at the same edge never conflict, due to bypass.
//  All arithmetic is DATA_W bits and wraps; no flags. -0x80 = 0x80.
//  DEST==SRC is legal. Writes to r0 are ordinary; there is no hardwired zero register.
//  RESET and INSTR_VALID together: RESET wins; the instruction is discarded.
// STRUCTURE
//  - cpu_pkg: opcode localparams (OP_LOADI..OP_OR), ALU select codes (SEL_FWD/ADD/AND/OR), field bit positions.
//  - Sub-module reg_file: NREGS x DATA_W, 2 combinational read ports, 1 synchronous write port.
//    Has CLK/RESET; sync clear.
//  - Top level holds decode, negation, bypass muxes and the issue/WB pipeline registers.
// TESTING
//  1. RESET 1 cycle -> DATA1=DATA2=0, SELECT=000, WB_EN=0; mov r1,r0 -> DATA2=0x00.
//  2. loadi r2,0x05; wait 2 edges -> reg[2]=0x05; mov r3,r2 issues DATA2=0x05, SELECT=000.
//  3. loadi r1,0x03 then immediately add r4,r1,r1 -> bypass: DATA1=DATA2=0x03, SELECT=001; r4=0x06.
//  4. r1=0x03, r2=0x05: sub r5,r1,r2 -> DATA2=0xFB, r5=0xFE; add r6,0xFF,0x01 wraps to 0x00.
//  5. Opcode 0x7F -> ILLEGAL_OP pulses 1 cycle, WB_EN=0, no register changes.
//  6. RESET asserted with WB_EN=1 (loadi r7,0xAA in flight) -> r7 stays 0x00, WB_EN=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode, ALU select and field-position constants
// for the decode/operand stage.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 2 ** ADDR_W;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] SEL_FWD = 3'b000;
  localparam logic [2:0] SEL_ADD = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;

  localparam int OP_LSB   = 24;
  localparam int DEST_LSB = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    OPB_REG,
    OPB_NEG,
    OPB_IMM
  } opb_e;

  typedef struct packed {
    logic       legal;
    logic [2:0] sel;
    opb_e       opb;
  } dec_t;

  function automatic dec_t decode(
    input logic [7:0] op
  );
    dec_t d;
    d = '{legal: 1'b1, sel: SEL_FWD,
          opb: OPB_REG};
    unique case (op)
      OP_LOADI: d.opb = OPB_IMM;
      OP_MOV:   d.sel = SEL_FWD;
      OP_ADD:   d.sel = SEL_ADD;
      OP_SUB: begin
        d.sel = SEL_ADD;
        d.opb = OPB_NEG;
      end
      OP_AND:   d.sel = SEL_AND;
      OP_OR:    d.sel = SEL_OR;
      default:  d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_file.sv
// NREGS x DATA_W register file: two combinational reads,
// one synchronous write, synchronous clear.
module reg_file
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/operand_stage.sv
// Decode/operand stage: reads sources with bypass, drives
// registered ALU operands and writes ALU results back.
module operand_stage
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  input  logic              INSTR_VALID,
  input  logic [DATA_W-1:0] ALU_RESULT,
  output logic [DATA_W-1:0] DATA1,
  output logic [DATA_W-1:0] DATA2,
  output logic [2:0]        SELECT,
  output logic              WB_EN,
  output logic [ADDR_W-1:0] WB_ADDR,
  output logic              ILLEGAL_OP
);

  logic [7:0]        op;
  logic [ADDR_W-1:0] dest, src1, src2;
  logic [DATA_W-1:0] imm;
  dec_t              dec;

  assign op   = INSTRUCTION[OP_LSB +: 8];
  assign dest = INSTRUCTION[DEST_LSB +: ADDR_W];
  assign src1 = INSTRUCTION[SRC1_LSB +: ADDR_W];
  assign src2 = INSTRUCTION[SRC2_LSB +: ADDR_W];
  assign imm  = INSTRUCTION[IMM_LSB +: DATA_W];
  assign dec  = decode(op);

  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [2:0]        sel_q, sel_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic              ill_q, ill_d;
  logic [DATA_W-1:0] rd1, rd2, opa, opb;

  reg_file u_rf (
    .CLK      (CLK),
    .RESET    (RESET),
    .we_i     (wb_en_q),
    .waddr_i  (wb_addr_q),
    .wdata_i  (ALU_RESULT),
    .raddr1_i (src1),
    .raddr2_i (src2),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  // The write landing this edge is not yet in the file.
  always_comb begin
    opa = rd1;
    opb = rd2;
    if (wb_en_q && src1 == wb_addr_q)
      opa = ALU_RESULT;
    if (wb_en_q && src2 == wb_addr_q)
      opb = ALU_RESULT;
  end

  always_comb begin
    d1_d      = d1_q;
    d2_d      = d2_q;
    sel_d     = sel_q;
    wb_addr_d = wb_addr_q;
    wb_en_d   = 1'b0;
    ill_d     = 1'b0;
    if (INSTR_VALID) begin
      if (dec.legal) begin
        d1_d      = opa;
        sel_d     = dec.sel;
        wb_en_d   = 1'b1;
        wb_addr_d = dest;
        unique case (dec.opb)
          OPB_IMM: d2_d = imm;
          OPB_NEG: d2_d = (~opb) + 1'b1;
          default: d2_d = opb;
        endcase
      end else begin
        ill_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      d1_q      <= '0;
      d2_q      <= '0;
      sel_q     <= SEL_FWD;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      ill_q     <= 1'b0;
    end else begin
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      sel_q     <= sel_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      ill_q     <= ill_d;
    end
  end

  assign DATA1      = d1_q;
  assign DATA2      = d2_q;
  assign SELECT     = sel_q;
  assign WB_EN      = wb_en_q;
  assign WB_ADDR    = wb_addr_q;
  assign ILLEGAL_OP = ill_q;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed vector table followed by
// random instruction streams against an ISA-level model.
module tb_operand_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic [7:0]  ALU_RESULT;
  logic [7:0]  DATA1, DATA2;
  logic [2:0]  SELECT;
  logic        WB_EN;
  logic [2:0]  WB_ADDR;
  logic        ILLEGAL_OP;

  int checks = 0;
  int errors = 0;

  operand_stage u_dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .INSTR_VALID (INSTR_VALID),
    .ALU_RESULT  (ALU_RESULT),
    .DATA1       (DATA1),
    .DATA2       (DATA2),
    .SELECT      (SELECT),
    .WB_EN       (WB_EN),
    .WB_ADDR     (WB_ADDR),
    .ILLEGAL_OP  (ILLEGAL_OP)
  );

  always #5 CLK = ~CLK;

  // Downstream 8-bit ALU
  always_comb begin
    ALU_RESULT = DATA2;
    case (SELECT)
      3'b001:  ALU_RESULT = DATA1 + DATA2;
      3'b010:  ALU_RESULT = DATA1 & DATA2;
      3'b011:  ALU_RESULT = DATA1 | DATA2;
      default: ALU_RESULT = DATA2;
    endcase
  end

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] ins;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [2:0]  sel;
    logic        wb;
    logic [2:0]  wa;
    logic        ill;
  } vec_t;

  vec_t tbl [20];

  logic [7:0] mregs [8];
  logic [7:0] e_d1, e_d2;
  logic [2:0] e_sel, e_wa;
  logic       e_wb, e_ill;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic step(input logic rst,
                      input logic v,
                      input logic [31:0] ins);
    @(negedge CLK);
    RESET       = rst;
    INSTR_VALID = v;
    INSTRUCTION = ins;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] ri(
    input logic [7:0] op, input logic [2:0] d,
    input logic [2:0] s1, input logic [2:0] s2);
    logic [31:0] r;
    r = '0;
    r[31:24] = op;
    r[18:16] = d;
    r[10:8]  = s1;
    r[2:0]   = s2;
    return r;
  endfunction

  function automatic logic [31:0] li(
    input logic [2:0] d, input logic [7:0] imm);
    logic [31:0] r;
    r = '0;
    r[18:16] = d;
    r[7:0]   = imm;
    return r;
  endfunction

  function automatic vec_t mk(
    input logic rst, input logic v,
    input logic [31:0] ins, input logic [7:0] d1,
    input logic [7:0] d2, input logic [2:0] sel,
    input logic wb, input logic [2:0] wa,
    input logic ill);
    vec_t t;
    t = '{rst, v, ins, d1, d2, sel, wb, wa, ill};
    return t;
  endfunction

  task automatic chk_regs(input string nm,
                          input logic [7:0] e [8]);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_r%0d", nm, i),
          32'(u_dut.u_rf.regs_q[i]), 32'(e[i]));
  endtask

  // ISA-level model: each instruction completes before the next.
  task automatic model(input logic rst,
                       input logic v,
                       input logic [31:0] ins);
    logic [7:0] op, a, b, res;
    logic [2:0] d, s1, s2;
    op = ins[31:24];
    d  = ins[18:16];
    s1 = ins[10:8];
    s2 = ins[2:0];
    e_wb  = 1'b0;
    e_ill = 1'b0;
    if (rst) begin
      for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
      e_d1 = 0; e_d2 = 0; e_sel = 0; e_wa = 0;
    end else if (v) begin
      if (op > 8'h05) begin
        e_ill = 1'b1;
      end else begin
        a = mregs[s1];
        b = mregs[s2];
        e_sel = 3'd0;
        if (op == 8'h00) b = ins[7:0];
        if (op == 8'h03) b = 8'(0 - int'(b));
        if (op == 8'h02 || op == 8'h03) e_sel = 3'd1;
        if (op == 8'h04) e_sel = 3'd2;
        if (op == 8'h05) e_sel = 3'd3;
        case (e_sel)
          3'd1:    res = a + b;
          3'd2:    res = a & b;
          3'd3:    res = a | b;
          default: res = b;
        endcase
        e_d1 = a;
        e_d2 = b;
        e_wb = 1'b1;
        e_wa = d;
        mregs[d] = res;
      end
    end
  endtask

  initial begin
    logic [7:0] er [8];
    logic [31:0] ins;
    logic        rst, v;
    int          pick;

    RESET       = 1'b1;
    INSTR_VALID = 1'b0;
    INSTRUCTION = '0;

    tbl[0]  = mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, ri(8'h01, 1, 0, 0),
                 8'h00, 8'h00, 0, 1, 1, 0);
    tbl[2]  = mk(0, 1, li(2, 8'h05),
                 8'h00, 8'h05, 0, 1, 2, 0);
    tbl[3]  = mk(0, 0, 0, 8'h00, 8'h05, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, ri(8'h01, 3, 0, 2),
                 8'h00, 8'h05, 0, 1, 3, 0);
    tbl[5]  = mk(0, 1, li(1, 8'h03),
                 8'h00, 8'h03, 0, 1, 1, 0);
    tbl[6]  = mk(0, 1, ri(8'h02, 4, 1, 1),
                 8'h03, 8'h03, 1, 1, 4, 0);
    tbl[7]  = mk(0, 1, ri(8'h03, 5, 1, 2),
                 8'h03, 8'hFB, 1, 1, 5, 0);
    tbl[8]  = mk(0, 1, li(6, 8'hFF),
                 8'h00, 8'hFF, 0, 1, 6, 0);
    tbl[9]  = mk(0, 1, li(7, 8'h01),
                 8'h00, 8'h01, 0, 1, 7, 0);
    tbl[10] = mk(0, 1, ri(8'h02, 6, 6, 7),
                 8'hFF, 8'h01, 1, 1, 6, 0);
    tbl[11] = mk(0, 1, ri(8'h01, 0, 0, 6),
                 8'h00, 8'h00, 0, 1, 0, 0);
    tbl[12] = mk(0, 1, ri(8'h04, 1, 2, 5),
                 8'h05, 8'hFE, 2, 1, 1, 0);
    tbl[13] = mk(0, 1, ri(8'h05, 3, 1, 4),
                 8'h04, 8'h06, 3, 1, 3, 0);
    tbl[14] = mk(0, 1, ri(8'h7F, 0, 0, 0),
                 8'h04, 8'h06, 3, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 8'h04, 8'h06, 3, 0, 0, 0);
    tbl[16] = mk(0, 1, li(7, 8'hAA),
                 8'h00, 8'hAA, 0, 1, 7, 0);
    tbl[17] = mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[18] = mk(1, 1, li(7, 8'h55),
                 8'h00, 8'h00, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].ins);
      chk($sformatf("v%0d_d1", i), 32'(DATA1),
          32'(tbl[i].d1));
      chk($sformatf("v%0d_d2", i), 32'(DATA2),
          32'(tbl[i].d2));
      chk($sformatf("v%0d_sel", i), 32'(SELECT),
          32'(tbl[i].sel));
      chk($sformatf("v%0d_wb", i), 32'(WB_EN),
          32'(tbl[i].wb));
      chk($sformatf("v%0d_ill", i), 32'(ILLEGAL_OP),
          32'(tbl[i].ill));
      if (tbl[i].wb || tbl[i].rst)
        chk($sformatf("v%0d_wa", i), 32'(WB_ADDR),
            32'(tbl[i].wa));
      if (i == 15) begin
        er = '{8'h00, 8'h04, 8'h05, 8'h06,
               8'h06, 8'hFE, 8'h00, 8'h01};
        chk_regs("dir", er);
      end
      if (i == 19) begin
        er = '{default: 8'h00};
        chk_regs("rst", er);
      end
    end

    // Random phase
    step(1, 0, 0);
    model(1, 0, 0);
    for (int n = 0; n < 600; n++) begin
      ins  = $urandom;
      pick = int'($urandom_range(0, 19));
      if (pick < 17) ins[31:24] = 8'(pick % 6);
      else if (pick == 17) ins[31:24] = 8'h7F;
      else ins[31:24] = 8'($urandom_range(6, 255));
      v   = ($urandom_range(0, 99) < 85);
      rst = ($urandom_range(0, 99) < 2);
      step(rst, v, ins);
      model(rst, v, ins);
      chk("rnd_d1", 32'(DATA1), 32'(e_d1));
      chk("rnd_d2", 32'(DATA2), 32'(e_d2));
      chk("rnd_sel", 32'(SELECT), 32'(e_sel));
      chk("rnd_wb", 32'(WB_EN), 32'(e_wb));
      chk("rnd_ill", 32'(ILLEGAL_OP), 32'(e_ill));
      if (e_wb)
        chk("rnd_wa", 32'(WB_ADDR), 32'(e_wa));
      if (!e_wb && (n % 8 == 0))
        chk_regs("rnd", mregs);
    end
    step(0, 0, 0);
    model(0, 0, 0);
    chk_regs("end", mregs);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
